qpsk_ber_checker: RTL and testbench

QPSK_BER_CHECKER -- requirements
Module: qpsk_ber_checker

---
 rtl/qpsk_pkg.sv | 27 ++
 rtl/sym_delay_line.sv | 32 +++
 rtl/qpsk_ber_checker.sv | 155 +++++++++++++++
 tb/tb_qpsk_ber_checker.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/qpsk_pkg.sv
// qpsk_pkg: shared definitions for the QPSK modulator, demodulator and BER
// checker so they all agree on symbol width and the checker FSM encoding.
//   SYM_W    - bits per QPSK symbol
//   ERR_W    - width needed to hold a per-symbol bit-error count (0..SYM_W)
//   state_e  - checker FSM states
//   popcnt_sym() - number of set bits in a symbol-wide vector
package qpsk_pkg;

    localparam int SYM_W = 2;
    localparam int ERR_W = $clog2(SYM_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    function automatic logic [ERR_W-1:0] popcnt_sym(input logic [SYM_W-1:0] x);
        logic [ERR_W-1:0] c;
        c = '0;
        for (int i = 0; i < SYM_W; i++) begin
            c = c + ERR_W'(x[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/sym_delay_line.sv
// sym_delay_line: fixed-depth shift register that aligns the transmitted
// {valid, sym} word with the demodulator output. Shifts every cycle.
//   clk    - clock, rising edge
//   rst    - asynchronous active-low reset, clears every stage
//   din_i  - word entering the line
//   dout_o - word as it entered DEPTH clocks earlier
module sym_delay_line #(
    parameter int DEPTH = 3,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);

    logic [DEPTH-1:0][W-1:0] pipe_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/qpsk_ber_checker.sv
// qpsk_ber_checker: measures symbol and bit error counts between the symbols
// fed to a QPSK modulator and the symbols recovered by the demodulator over a
// window of WINDOW valid symbols.
//   clk          - clock, rising edge
//   rst          - asynchronous active-low reset
//   start        - one-cycle request to begin a measurement (ignored while busy)
//   ref_valid    - ref_sym carries a transmitted symbol this cycle
//   ref_sym      - symbol fed to the modulator
//   rx_sym       - demodulator output, LATENCY clocks behind ref_sym
//   busy         - measurement in progress
//   done         - counters hold the final result
//   sym_cnt      - symbols compared so far
//   sym_err_cnt  - symbols with at least one wrong bit (saturating)
//   bit_err_cnt  - total wrong bits (saturating)
//   err_pulse    - one-cycle pulse per counted symbol error
module qpsk_ber_checker
    import qpsk_pkg::*;
#(
    parameter int LATENCY = 3,
    parameter int WINDOW  = 512,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ref_valid,
    input  logic [SYM_W-1:0] ref_sym,
    input  logic [SYM_W-1:0] rx_sym,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sym_cnt,
    output logic [CNT_W-1:0] sym_err_cnt,
    output logic [CNT_W-1:0] bit_err_cnt,
    output logic             err_pulse
);

    localparam logic [CNT_W-1:0] WIN_C   = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ---------------------------------------------------------------
    // Reference alignment
    // ---------------------------------------------------------------
    logic [SYM_W:0]   dly_w;
    logic             dly_valid;
    logic [SYM_W-1:0] dly_sym;

    sym_delay_line #(
        .DEPTH (LATENCY),
        .W     (SYM_W + 1)
    ) u_dly (
        .clk    (clk),
        .rst    (rst),
        .din_i  ({ref_valid, ref_sym}),
        .dout_o (dly_w)
    );

    assign dly_valid = dly_w[SYM_W];
    assign dly_sym   = dly_w[SYM_W-1:0];

    // ---------------------------------------------------------------
    // Compare
    // ---------------------------------------------------------------
    logic [SYM_W-1:0] diff_w;
    logic [ERR_W-1:0] nbit_w;
    logic             sym_bad_w;
    logic             cmp_w;

    assign diff_w    = dly_sym ^ rx_sym;
    assign nbit_w    = popcnt_sym(diff_w);
    assign sym_bad_w = |diff_w;

    // ---------------------------------------------------------------
    // FSM + counters
    // ---------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0] serr_q, serr_d;
    logic [CNT_W-1:0] berr_q, berr_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W:0]   bsum_w;

    assign cmp_w  = dly_valid && (state_q == ST_MEASURE);
    // One extra bit catches the carry so the bit counter can clamp at all-ones.
    assign bsum_w = {1'b0, berr_q} + (CNT_W+1)'(nbit_w);

    always_comb begin
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q;
        serr_d    = serr_q;
        berr_d    = berr_q;
        pulse_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Delayed valids arriving now are not counted: state is not
                // MEASURE yet, so counting begins on the following cycle.
                if (start) begin
                    state_d   = ST_MEASURE;
                    sym_cnt_d = '0;
                    serr_d    = '0;
                    berr_d    = '0;
                end
            end
            ST_MEASURE: begin
                if (cmp_w) begin
                    sym_cnt_d = sym_cnt_q + 1'b1;
                    if (sym_bad_w) begin
                        pulse_d = 1'b1;
                        if (serr_q != CNT_MAX) begin
                            serr_d = serr_q + 1'b1;
                        end
                        berr_d = bsum_w[CNT_W] ? CNT_MAX : bsum_w[CNT_W-1:0];
                    end
                    if (sym_cnt_d == WIN_C) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_MEASURE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            sym_cnt_q <= '0;
            serr_q    <= '0;
            berr_q    <= '0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
            serr_q    <= serr_d;
            berr_q    <= berr_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign sym_cnt     = sym_cnt_q;
    assign sym_err_cnt = serr_q;
    assign bit_err_cnt = berr_q;
    assign err_pulse   = pulse_q;

endmodule

// File: tb/tb_qpsk_ber_checker.sv
// Directed bench: instance A (LATENCY=3, WINDOW=8, CNT_W=16) for the
// functional cases, instance B (LATENCY=3, WINDOW=15, CNT_W=4) fed an
// inverted receive stream for saturation.
module tb_qpsk_ber_checker;

    logic        clk;
    logic        rst;
    logic        start_a, start_b;
    logic        ref_valid;
    logic [1:0]  ref_sym;
    logic [1:0]  rx_a, rx_b;
    logic        busy_a, done_a, pulse_a;
    logic [15:0] sc_a, se_a, be_a;
    logic        busy_b, done_b, pulse_b;
    logic [3:0]  sc_b, se_b, be_b;

    int vectors = 0;
    int errs    = 0;
    int pulses_a = 0;
    int p0;
    logic rel_req = 1'b0;

    // bench-side LATENCY=3 history of what rx should be
    logic [1:0] ha [3];
    logic [1:0] hb [3];

    qpsk_ber_checker #(.LATENCY(3), .WINDOW(8), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .ref_valid(ref_valid),
        .ref_sym(ref_sym), .rx_sym(rx_a), .busy(busy_a), .done(done_a),
        .sym_cnt(sc_a), .sym_err_cnt(se_a), .bit_err_cnt(be_a),
        .err_pulse(pulse_a)
    );

    qpsk_ber_checker #(.LATENCY(3), .WINDOW(15), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .ref_valid(ref_valid),
        .ref_sym(ref_sym), .rx_sym(rx_b), .busy(busy_b), .done(done_b),
        .sym_cnt(sc_b), .sym_err_cnt(se_b), .bit_err_cnt(be_b),
        .err_pulse(pulse_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (pulse_a === 1'b1) pulses_a++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Sets this cycle's inputs at the falling edge; outputs read right after
    // the call reflect the preceding rising edge.
    task automatic drive(input logic sa, input logic sb, input logic v,
                         input logic [1:0] s, input logic [1:0] m);
        @(negedge clk);
        if (rel_req) begin
            rst     = 1'b1;
            rel_req = 1'b0;
        end
        rx_a  = ha[2];
        rx_b  = hb[2];
        ha[2] = ha[1]; ha[1] = ha[0]; ha[0] = s ^ m;
        hb[2] = hb[1]; hb[1] = hb[0]; hb[0] = ~s;
        start_a   = sa;
        start_b   = sb;
        ref_valid = v;
        ref_sym   = s;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    task automatic clr_hist();
        for (int k = 0; k < 3; k++) begin
            ha[k] = 2'b00;
            hb[k] = 2'b00;
        end
    endtask

    initial begin
        rst = 1'b0; start_a = 0; start_b = 0; ref_valid = 0; ref_sym = 0;
        rx_a = 0; rx_b = 0;
        clr_hist();
        #3;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_sym_cnt", sc_a, 0);
        chk("rst_bit_err", be_a, 0);
        idle(2);

        // Clean run on A, fully inverted run on B; start on first edge after release.
        rel_req = 1'b1;
        for (int i = 0; i <= 18; i++) begin
            drive(i == 0, i == 0, 1'b1, 2'(i), 2'b00);
            case (i)
                1:  begin chk("t1_busy", busy_a, 1); chk("t1_cnt0", sc_a, 0); end
                10: begin chk("t1_cnt7", sc_a, 7); chk("t1_notdone", done_a, 0); end
                11: begin
                    chk("t1_done", done_a, 1); chk("t1_busy_lo", busy_a, 0);
                    chk("t1_cnt8", sc_a, 8); chk("t1_serr", se_a, 0);
                    chk("t1_berr", be_a, 0);
                end
                12: begin chk("sat_berr_mid", be_b, 15); chk("sat_serr_mid", se_b, 9); end
                18: begin
                    chk("t1_hold_cnt", sc_a, 8);
                    chk("sat_done", done_b, 1); chk("sat_cnt", sc_b, 15);
                    chk("sat_serr", se_b, 15); chk("sat_berr", be_b, 15);
                end
                default: ;
            endcase
        end

        // Errors on symbols 2 (one bit) and 5 (two bits); start mid-run ignored;
        // restart from DONE clears results.
        idle(4);
        p0 = pulses_a;
        for (int i = 0; i <= 11; i++) begin
            drive(i == 0 || i == 5, 1'b0, 1'b1, 2'(i),
                  (i == 2) ? 2'b01 : ((i == 5) ? 2'b11 : 2'b00));
            case (i)
                1:  begin chk("t2_done_fell", done_a, 0); chk("t2_cleared", sc_a, 0); end
                6:  begin
                    chk("t2_ignore_start", sc_a, 3); chk("t2_pulse", pulse_a, 1);
                    chk("t2_serr_mid", se_a, 1);
                end
                11: begin
                    chk("t2_done", done_a, 1); chk("t2_cnt", sc_a, 8);
                    chk("t2_serr", se_a, 2); chk("t2_berr", be_a, 3);
                end
                default: ;
            endcase
        end
        idle(2);
        chk("t2_pulse_cnt", pulses_a - p0, 2);

        // ref_valid every other cycle.
        idle(4);
        for (int i = 0; i <= 18; i++) begin
            drive(i == 0, 1'b0, (i % 2) == 0, 2'(i), 2'b00);
            case (i)
                10: chk("t3_cnt4", sc_a, 4);
                17: begin
                    chk("t3_notdone", done_a, 0); chk("t3_cnt7", sc_a, 7);
                    chk("t3_busy", busy_a, 1);
                end
                18: begin chk("t3_done", done_a, 1); chk("t3_cnt8", sc_a, 8); end
                default: ;
            endcase
        end

        // Async reset mid-measurement at sym_cnt=4.
        idle(4);
        for (int i = 0; i <= 7; i++) begin
            drive(i == 0, 1'b0, 1'b1, 2'(i), (i == 1) ? 2'b10 : 2'b00);
        end
        chk("t4_pre_cnt", sc_a, 4);
        chk("t4_pre_serr", se_a, 1);
        #2 rst = 1'b0;
        #1;
        chk("t4_rst_cnt", sc_a, 0);
        chk("t4_rst_serr", se_a, 0);
        chk("t4_rst_berr", be_a, 0);
        chk("t4_rst_busy", busy_a, 0);
        chk("t4_rst_done", done_a, 0);
        chk("t4_rst_doneb", done_b, 0);
        clr_hist();
        idle(1);
        chk("t4_held_busy", busy_a, 0);
        rel_req = 1'b1;
        for (int i = 0; i <= 11; i++) begin
            drive(i == 0, 1'b0, 1'b1, 2'(i), 2'b00);
            case (i)
                1:  begin chk("t4_busy", busy_a, 1); chk("t4_cnt0", sc_a, 0); end
                11: begin
                    chk("t4_done", done_a, 1); chk("t4_cnt8", sc_a, 8);
                    chk("t4_serr", se_a, 0); chk("t4_berr", be_a, 0);
                end
                default: ;
            endcase
        end

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
